fpcvt_pipe: RTL and testbench
=============================

# fpcvt_pipe

Pipelined, parametrised converter from two's-complement integers to a compact sign/exponent/mantissa floating-point format (value = (−1)^S · F · 2^E). It generalises the existing combinational 13-bit → 1/3/5 converter: data, exponent and mantissa widths are parameters, rounding mode is selectable per sample, and conversion runs as a 3-stage pipeline with valid/ready flow control. It sits between integer sample producers and the floating-point display/storage path.

## Interface
- DW, 13, input integer width (two's complement); DW ≥ MW+1
- EW, 3, exponent width; EMAX = 2^EW − 1
- MW, 5, mantissa width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DW  two's-complement input
- in_rnd  in  1  0 = truncate, 1 = round half-up on magnitude; travels with its sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_s  out  1  sign
- out_e  out  EW  exponent
- out_f  out  MW  mantissa
- out_sat  out  1  result was clamped to the largest magnitude

## Operation
- Transfer occurs on a cycle where valid && ready (both ports).
- Stage 1: S = in_data[DW−1]; mag = |in_data| in DW bits (unsigned); −2^(DW−1) yields mag = 2^(DW−1), no overflow.
- Stage 2: p = index of highest set bit of mag (mag = 0 → E = 0, F = 0). E0 = max(0, p − (MW−1)). F0 = mag >> E0, truncated to MW bits. R = mag[E0−1] if E0 > 0, else 0. If E0 > EMAX: flag saturation.
- Stage 3 (round/clamp):
  - saturation flagged → E = EMAX, F = all ones, sat = 1.
  - in_rnd = 0 or R = 0 → E = E0, F = F0, sat = 0.
  - R = 1, F0 ≠ all ones → F = F0 + 1, E = E0.
  - R = 1, F0 = all ones, E0 < EMAX → F = 1 followed by MW−1 zeros, E = E0 + 1.
  - R = 1, F0 = all ones, E0 = EMAX → E = EMAX, F = all ones, sat = 1.
- S is passed through unchanged, including for zero input (D = 0 → S = 0).
- Every exponent position E0 ∈ 0..EMAX uses the same uniform slice mag[E0+MW−1 : E0]; no per-exponent special cases.

## Timing
- Latency: 3 cycles from input transfer to out_valid, provided there is no backpressure.
- Throughput: 1 sample/cycle while out_ready = 1.
- Global advance enable adv = !out_valid || out_ready. All stages, including the stage valids, shift only when adv = 1. in_ready = adv, combinational from out_valid/out_ready only. in_ready does not depend on in_valid.
- While adv = 0, all outputs hold stable. A bubble (in_valid = 0 on an advancing cycle) propagates as an invalid stage.
- Sample order is preserved. No sample is dropped or duplicated.
- Reset: on any cycle with rst = 1, all stage valids clear at that edge and any in-flight samples are discarded.
  - Output reset values: out_valid = 0, out_s = 0, out_e = 0, out_f = 0, out_sat = 0.
  - in_ready = 1 on the cycle after reset.
  - A transfer presented during a rst cycle is ignored.
- out_s/e/f/sat are registered. When out_valid = 0 their value is don't-care (reset to 0).

## Test plan
- Exact and zero values (defaults, rnd = 1): D = 0 → S0 E0 F0. D = 56 → S0 E1 F28 sat 0. D = 31 → E0 F31.
- Rounding carry (rnd = 1): D = 127 → E3 F16. D = −127 (13'h1F81) → S1 E3 F16. Same D = 127 with rnd = 0 → E2 F31.
- Mid-exponent slice: D = 1000 → E5 F31. D = 1020 (rnd = 1) → E6 F16.
- Saturation: D = 4095, rnd = 1 → E7 F31 sat 1. D = 4095, rnd = 0 → E7 F31 sat 0. D = −4096 (13'h1000) → S1 E7 F31 sat 1.
- Backpressure:
  - Stimulus: stream 10 back-to-back samples; hold out_ready = 0 for 5 cycles mid-stream.
  - Required: in_ready drops within the same cycle once the pipe is full; outputs stay stable during the stall; all 10 results emerge in order, matching a reference model.
  - Also check 3-cycle latency with out_ready = 1.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight → out_valid = 0 next cycle, no stale result ever emerges, next sample appears exactly 3 cycles after its transfer.

Source files
------------

// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined converter from two's-complement integers to sign/exponent/mantissa
// floating point (value = (-1)^S * F * 2^E), with per-sample truncate or round-half-up.
module fpcvt_pipe #(
    parameter int unsigned DW = 13,
    parameter int unsigned EW = 3,
    parameter int unsigned MW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat
);

    localparam int unsigned   PW      = $clog2(DW) + 1;
    localparam int unsigned   EMAX    = (1 << EW) - 1;
    localparam logic [EW-1:0] E_MAX   = '1;
    localparam logic [MW-1:0] F_ONES  = '1;
    localparam logic [MW-1:0] F_CARRY = MW'(1 << (MW - 1));

    logic adv;

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: sign and magnitude
    logic          s1_valid_q, s1_s_q, s1_rnd_q;
    logic [DW-1:0] s1_mag_q;
    logic [DW-1:0] mag_d;

    // -2^(DW-1) maps to 2^(DW-1), which still fits as an unsigned DW-bit value.
    assign mag_d = in_data[DW-1] ? (~in_data + DW'(1)) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_rnd_q   <= 1'b0;
            s1_mag_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s1_s_q     <= in_data[DW-1];
            s1_rnd_q   <= in_rnd;
            s1_mag_q   <= mag_d;
        end
    end

    // Stage 2: normalise into a uniform MW-bit slice
    logic          s2_valid_q, s2_s_q, s2_rnd_q, s2_r_q, s2_sat_q;
    logic [EW-1:0] s2_e0_q;
    logic [MW-1:0] s2_f0_q;
    logic [PW-1:0] msb, e0;
    logic [MW-1:0] f0_d;
    logic          r_d, sat_d;

    always_comb begin
        msb = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (s1_mag_q[i]) msb = PW'(i);
        end
        e0    = (msb >= PW'(MW - 1)) ? (msb - PW'(MW - 1)) : '0;
        f0_d  = MW'(s1_mag_q >> e0);
        r_d   = (e0 != '0) && 1'(s1_mag_q >> (e0 - PW'(1)));
        sat_d = 32'(e0) > EMAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_s_q     <= 1'b0;
            s2_rnd_q   <= 1'b0;
            s2_r_q     <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_e0_q    <= '0;
            s2_f0_q    <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_s_q     <= s1_s_q;
            s2_rnd_q   <= s1_rnd_q;
            s2_r_q     <= r_d;
            s2_sat_q   <= sat_d;
            s2_e0_q    <= EW'(e0);
            s2_f0_q    <= f0_d;
        end
    end

    // Stage 3: round and clamp
    logic [EW-1:0] e_d;
    logic [MW-1:0] f_d;
    logic          sat3_d;

    always_comb begin
        e_d    = s2_e0_q;
        f_d    = s2_f0_q;
        sat3_d = 1'b0;
        if (s2_sat_q) begin
            e_d    = E_MAX;
            f_d    = F_ONES;
            sat3_d = 1'b1;
        end else if (s2_rnd_q && s2_r_q) begin
            if (s2_f0_q != F_ONES) begin
                f_d = s2_f0_q + MW'(1);
            end else if (s2_e0_q != E_MAX) begin
                // Mantissa overflow renormalises into the next exponent.
                f_d = F_CARRY;
                e_d = s2_e0_q + EW'(1);
            end else begin
                e_d    = E_MAX;
                f_d    = F_ONES;
                sat3_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid_q;
            out_s     <= s2_s_q;
            out_e     <= e_d;
            out_f     <= f_d;
            out_sat   <= sat3_d;
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: arithmetic reference model, scoreboard checked every cycle,
// directed vectors with literal expectations, backpressure and mid-stream reset.
module tb_fpcvt_pipe;

    localparam int DW   = 13;
    localparam int EW   = 3;
    localparam int MW   = 5;
    localparam int EMAX = (1 << EW) - 1;
    localparam int NV   = 12;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
        logic          sat;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
        bit   timed;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_rnd;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_s, out_sat;
    logic [EW-1:0] out_e;
    logic [MW-1:0] out_f;

    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    bit   free_run;
    bit   hold   = 1'b0;
    res_t prev;
    exp_t sb[$];

    int vd[NV] = '{0, 56, 31, 127, -127, 127, 1000, 1020, 4095, 4095, -4096, -1};
    int vr[NV] = '{1, 1,  1,  1,   1,    0,   1,    1,    1,    0,    1,     1};
    int xs[NV] = '{0, 0,  0,  0,   1,    0,   0,    0,    0,    0,    1,     1};
    int xe[NV] = '{0, 1,  0,  3,   3,    2,   5,    6,    7,    7,    7,     0};
    int xf[NV] = '{0, 28, 31, 16,  16,   31,  31,   16,   31,   31,   31,    1};
    int xt[NV] = '{0, 0,  0,  0,   0,    0,   0,    0,    1,    0,    1,     0};

    fpcvt_pipe #(.DW(DW), .EW(EW), .MW(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_rnd   (in_rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_e    (out_e),
        .out_f    (out_f),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Value-level model: quantise |D| to MW significant bits by scaling, then clamp.
    function automatic res_t model(input logic [DW-1:0] d, input logic rnd);
        res_t res;
        int   mag, p, e0, e, q;
        res.s   = d[DW-1];
        res.sat = 1'b0;
        mag     = d[DW-1] ? (1 << DW) - int'(d) : int'(d);
        if (mag == 0) begin
            res.e = '0;
            res.f = '0;
            return res;
        end
        p  = $clog2(mag + 1) - 1;
        e0 = (p > MW - 1) ? p - (MW - 1) : 0;
        if (e0 > EMAX) begin
            res.e   = EW'(EMAX);
            res.f   = '1;
            res.sat = 1'b1;
            return res;
        end
        q = (rnd && e0 > 0) ? (mag + (1 << (e0 - 1))) >> e0 : mag >> e0;
        e = e0;
        if (q == (1 << MW)) begin
            q = 1 << (MW - 1);
            e = e0 + 1;
        end
        if (e > EMAX) begin
            e       = EMAX;
            q       = (1 << MW) - 1;
            res.sat = 1'b1;
        end
        res.e = EW'(e);
        res.f = MW'(q);
        return res;
    endfunction

    // Scoreboard and protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (hold) chk("stall_stable", int'({out_s, out_e, out_f, out_sat}), int'(prev));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL stale_output: got result e=%0d f=%0d, expected none",
                             out_e, out_f);
                end else begin
                    x = sb.pop_front();
                    chk("out_s", int'(out_s), int'(x.r.s));
                    chk("out_e", int'(out_e), int'(x.r.e));
                    chk("out_f", int'(out_f), int'(x.r.f));
                    chk("out_sat", int'(out_sat), int'(x.r.sat));
                    if (x.timed) chk("latency", cyc - x.cyc, 3);
                end
            end
            if (in_valid && in_ready) begin
                x.r     = model(in_data, in_rnd);
                x.cyc   = cyc;
                x.timed = free_run;
                sb.push_back(x);
            end
            hold = out_valid && !out_ready;
            prev = '{s: out_s, e: out_e, f: out_f, sat: out_sat};
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic r);
        bit go;
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = r;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            go = in_ready && !rst;
            @(posedge clk);
            #1;
            if (go) break;
            if (i >= 50) begin
                checks++;
                $display("FAIL send_timeout: got no transfer, expected one within 50 cycles");
                break;
            end
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) return;
            @(posedge clk);
            #1;
        end
        checks++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    endtask

    initial begin
        res_t m;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b1;
        free_run  = 1'b1;

        for (int i = 0; i < NV; i++) begin
            m = model(DW'(vd[i]), vr[i] != 0);
            chk($sformatf("model_s[%0d]", vd[i]), int'(m.s), xs[i]);
            chk($sformatf("model_e[%0d]", vd[i]), int'(m.e), xe[i]);
            chk($sformatf("model_f[%0d]", vd[i]), int'(m.f), xf[i]);
            chk($sformatf("model_sat[%0d]", vd[i]), int'(m.sat), xt[i]);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_outputs", int'({out_s, out_e, out_f, out_sat}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed vectors, back to back with no backpressure.
        for (int i = 0; i < NV; i++) send(DW'(vd[i]), vr[i] != 0);
        drain();

        // Ten-sample stream with a five-cycle downstream stall.
        free_run = 1'b0;
        fork
            for (int i = 0; i < 10; i++) send(DW'(i * 517 - 2400), i[0]);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(posedge clk);
                #1;
                chk("stall_in_ready_low", int'(in_ready), 0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        free_run = 1'b1;

        // Reset with three samples in flight; the sample offered during reset is ignored.
        send(DW'(200), 1'b1);
        send(DW'(-300), 1'b0);
        send(DW'(4000), 1'b1);
        rst     = 1'b1;
        in_data = DW'(777);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        repeat (4) @(posedge clk);
        #1;
        send(DW'(300), 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
